uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period
// common to the RX and TX blocks.
package uart_pkg;

   localparam int UART_CLKS_PER_BIT = 2500;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; both stages load
// RESET_VALUE on reset so an idle line does not look like an edge.
module sync_2ff #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_reg <= RESET_VALUE;
         sync_reg <= RESET_VALUE;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: falling-edge start detect, mid-bit sampling, one-cycle
// valid / framing-error strobes.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_signal,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       framing_error,
   output logic       busy
);

   localparam int          HALF_BIT  = CLKS_PER_BIT / 2;
   localparam logic [31:0] HALF_LAST = 32'(HALF_BIT - 1);
   localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);

   logic       rx_s;
   rx_state_t  state_reg, state_next;
   logic [31:0] cnt_reg, cnt_next;
   logic [2:0] bit_reg, bit_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] data_reg, data_next;
   logic       valid_reg, valid_next;
   logic       ferr_reg, ferr_next;
   logic       busy_reg, busy_next;
   logic       rx_prev_reg;

   sync_2ff #(
      .WIDTH       (1),
      .RESET_VALUE (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_signal),
      .q     (rx_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_reg     <= '0;
         shift_reg   <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         ferr_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         rx_prev_reg <= 1'b1;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_reg     <= bit_next;
         shift_reg   <= shift_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         ferr_reg    <= ferr_next;
         busy_reg    <= busy_next;
         rx_prev_reg <= rx_s;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 32'd1;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      data_next  = data_reg;
      valid_next = 1'b0;
      ferr_next  = 1'b0;
      busy_next  = busy_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            // Edge-triggered so a line stuck low can never arm a frame.
            if (rx_prev_reg && !rx_s) begin
               busy_next  = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next = '0;
               if (!rx_s) begin
                  bit_next   = '0;
                  state_next = DATA;
               end else begin
                  busy_next  = 1'b0;
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next   = '0;
               shift_next = {rx_s, shift_reg[7:1]};
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit leaves time to catch a back-to-back start edge.
            if (cnt_reg == BIT_LAST) begin
               cnt_next   = '0;
               busy_next  = 1'b0;
               state_next = IDLE;
               if (rx_s) begin
                  data_next  = shift_reg;
                  valid_next = 1'b1;
               end else begin
                  ferr_next  = 1'b1;
               end
            end
         end
         default: begin
            cnt_next   = '0;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   assign rx_data       = data_reg;
   assign rx_valid      = valid_reg;
   assign framing_error = ferr_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, a negedge
// monitor pops and checks kind, data, latency and busy at each strobe.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   localparam int LAT  = HALF + 9 * CPB + 3;

   typedef struct {
      logic       ferr;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_line = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       framing_error;
   logic       busy;

   exp_t       exp_q[$];
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;
   logic [7:0] last_good = 8'h00;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_signal     (rx_line),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .framing_error (framing_error),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog sim_time_exceeded pending=%0d", exp_q.size());
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int actual, input int required);
      tests++;
      if (actual != required) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && (rx_valid || framing_error)) begin
         exp_t e;
         tests++;
         if (rx_valid && framing_error) begin
            fails++;
            $display("FAIL strobe_exclusive valid=1 ferr=1 required one of them");
         end
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe valid=%0d ferr=%0d data=%02h cyc=%0d",
                     rx_valid, framing_error, rx_data, cyc);
         end else begin
            e = exp_q.pop_front();
            check("strobe_kind_ferr", int'(framing_error), int'(e.ferr));
            check("strobe_data", int'(rx_data), int'(e.data));
            check("strobe_busy_low", int'(busy), 0);
            tests++;
            if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
               fails++;
               $display("FAIL strobe_latency cyc=%0d required=%0d+-1", cyc, e.cyc);
            end
            $display("[TB] strobe %s data=%02h cyc=%0d", e.ferr ? "ferr" : "valid",
                     rx_data, cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      exp_t e;
      e.ferr = !stop_bit;
      e.data = stop_bit ? data : last_good;
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
      if (stop_bit) last_good = data;
      rx_line = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_line = data[i];
         tick(CPB);
      end
      rx_line = stop_bit;
      tick(CPB);
      rx_line = 1'b1;
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 40 * CPB;
      while (exp_q.size() != 0 && budget > 0) begin
         tick(1);
         budget--;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      tick(3);
      check("reset_rx_data", int'(rx_data), 0);
      check("reset_rx_valid", int'(rx_valid), 0);
      check("reset_ferr", int'(framing_error), 0);
      check("reset_busy", int'(busy), 0);
      reset = 1'b0;
      tick(2 * CPB);

      send_frame(8'h55, 1'b1);
      tick(CPB);
      drain("t1_single_byte");

      send_frame(8'hA3, 1'b1);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      tick(CPB);
      drain("t2_back_to_back");

      send_frame(8'h3C, 1'b0);
      tick(2 * CPB);
      send_frame(8'h81, 1'b1);
      tick(CPB);
      drain("t3_framing_then_good");

      rx_line = 1'b0;
      tick(5);
      check("t4_glitch_busy_high", int'(busy), 1);
      tick(1);
      rx_line = 1'b1;
      tick(HALF);
      check("t4_glitch_busy_low", int'(busy), 0);
      tick(2 * CPB);
      send_frame(8'h42, 1'b1);
      tick(CPB);
      drain("t4_after_glitch");

      begin
         exp_t e;
         e.ferr = 1'b1;
         e.data = last_good;
         e.cyc  = cyc + LAT;
         exp_q.push_back(e);
         rx_line = 1'b0;
         tick(20 * CPB);
         rx_line = 1'b1;
         tick(2 * CPB);
      end
      check("t5_stuck_low_one_ferr", exp_q.size(), 0);
      send_frame(8'h7E, 1'b1);
      tick(CPB);
      drain("t5_after_stuck_low");

      // Aborted 0x99: start, bits 0..3, then reset mid bit 4; the transmitter
      // shares the reset and returns the line to idle.
      rx_line = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_line = (8'h99 >> i) & 8'h01;
         tick(CPB);
      end
      rx_line = 1'b1;
      tick(HALF);
      check("t6_busy_before_reset", int'(busy), 1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("t6_reset_rx_data", int'(rx_data), 0);
      check("t6_reset_busy", int'(busy), 0);
      check("t6_reset_valid", int'(rx_valid), 0);
      check("t6_reset_ferr", int'(framing_error), 0);
      last_good = 8'h00;
      tick(12 * CPB);
      check("t6_no_strobe_aborted", exp_q.size(), 0);
      send_frame(8'h99, 1'b1);
      tick(CPB);
      drain("t6_after_reset");

      tick(2 * CPB);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
